// File: rtl/fu_iq_pkg.sv
// Shared types for the functional-unit issue queue.
// Entry fields are sized by IQ_PRN_W/IQ_ID_W, which set the widest PRN/ROB id the queue can hold.
package fu_iq_pkg;

  localparam int NUM_SRC  = 3;
  localparam int NUM_WB   = 3;
  localparam int IQ_PRN_W = 6;
  localparam int IQ_ID_W  = 6;

  typedef struct packed {
    logic [IQ_PRN_W-1:0] prn;
    logic                rdy;
    logic [63:0]         val;
  } iq_src_t;

  typedef struct packed {
    logic                               valid;
    logic [31:0]                        inst;
    logic [IQ_ID_W-1:0]                 inst_id;
    logic [63:0]                        pc;
    iq_src_t [NUM_SRC-1:0]              src;
    logic [NUM_SRC-1:0][IQ_PRN_W-1:0]   dst_prn;
    logic [NUM_SRC-1:0]                 dst_prn_valid;
  } iq_entry_t;

endpackage

// File: rtl/fu_iq_select.sv
// Lowest-index-first picker over a request vector.
// It returns a one-hot grant, the binary index of that grant, and an any-request flag.
module fu_iq_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
    any_o          = |req_i;
    grant_o        = '0;
    grant_o[idx_o] = any_o;
  end

endmodule

// File: rtl/fu_issue_queue.sv
// Collapsing issue queue for one FU: wakeup from writeback, oldest-ready select, registered issue.
// Defining FU_IQ_WAKEUP_BYPASS_EN lets same-cycle writeback wakeups take part in select.
module fu_issue_queue
  import fu_iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRN_W = 6,
  parameter int ID_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [31:0]        disp_inst,
  input  logic [ID_W-1:0]    disp_inst_id,
  input  logic [63:0]        disp_pc,
  input  logic [PRN_W-1:0]   disp_src_prn [NUM_SRC],
  input  logic [NUM_SRC-1:0] disp_src_rdy,
  input  logic [63:0]        disp_src_val [NUM_SRC],
  input  logic [PRN_W-1:0]   disp_dst_prn [NUM_SRC],
  input  logic [NUM_SRC-1:0] disp_dst_prn_valid,
  input  logic               wb_valid,
  input  logic [PRN_W-1:0]   wb_prn [NUM_WB],
  input  logic [63:0]        wb_data [NUM_WB],
  input  logic [NUM_WB-1:0]  wb_data_valid,
  input  logic               fu_ready,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [ID_W-1:0]    inst_id,
  output logic [63:0]        pc,
  output logic [63:0]        op [NUM_SRC],
  output logic [PRN_W-1:0]   out_prn [NUM_SRC],
  output logic [NUM_SRC-1:0] out_prn_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t          entries_q [DEPTH];
  iq_entry_t          entries_d [DEPTH];
  iq_entry_t          woken     [DEPTH];
  iq_entry_t          shifted   [DEPTH];
  iq_entry_t          disp_entry;
  logic [CNT_W-1:0]   count_q, count_d, count_left;
  logic [DEPTH-1:0]   cand, sel_grant, shift_en;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any, issue, dispatch;
  logic [64:0]        wk_m, dp_m;

  logic               inst_valid_q;
  logic [31:0]        inst_q;
  logic [ID_W-1:0]    inst_id_q;
  logic [63:0]        pc_q;
  logic [63:0]        op_q      [NUM_SRC];
  logic [PRN_W-1:0]   out_prn_q [NUM_SRC];
  logic [NUM_SRC-1:0] out_prn_valid_q;

  // Returns {hit, data}; iterating downward makes the lowest matching lane win.
  function automatic logic [64:0] wb_match(input logic [IQ_PRN_W-1:0] prn);
    logic [64:0] r;
    r = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_valid && wb_data_valid[k] && (IQ_PRN_W'(wb_prn[k]) == prn)) r = {1'b1, wb_data[k]};
    end
    return r;
  endfunction

  assign disp_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign dispatch   = disp_valid && disp_ready;

  always_comb begin
    wk_m = '0;
    cand = '0;
    for (int e = 0; e < DEPTH; e++) begin
      woken[e] = entries_q[e];
      cand[e]  = fu_ready && entries_q[e].valid;
      for (int s = 0; s < NUM_SRC; s++) begin
        wk_m = wb_match(entries_q[e].src[s].prn);
        if (!entries_q[e].src[s].rdy && wk_m[64]) begin
          woken[e].src[s].rdy = 1'b1;
          woken[e].src[s].val = wk_m[63:0];
        end
`ifdef FU_IQ_WAKEUP_BYPASS_EN
        cand[e] = cand[e] && woken[e].src[s].rdy;
`else
        cand[e] = cand[e] && entries_q[e].src[s].rdy;
`endif
      end
    end
  end

  fu_iq_select #(.N(DEPTH)) u_select (
    .req_i   (cand),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  assign issue = sel_any && !flush;

  // The issued slot and everything younger move down one place.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_collapse
    assign shift_en[gi] = issue && (|sel_grant[gi:0]);
    if (gi == DEPTH - 1) begin : g_last
      assign shifted[gi] = shift_en[gi] ? iq_entry_t'('0) : woken[gi];
    end else begin : g_mid
      assign shifted[gi] = shift_en[gi] ? woken[gi+1] : woken[gi];
    end
  end

  always_comb begin
    dp_m                          = '0;
    disp_entry                    = '0;
    disp_entry.valid              = 1'b1;
    disp_entry.inst               = disp_inst;
    disp_entry.inst_id            = IQ_ID_W'(disp_inst_id);
    disp_entry.pc                 = disp_pc;
    disp_entry.dst_prn_valid      = disp_dst_prn_valid;
    for (int s = 0; s < NUM_SRC; s++) begin
      dp_m                        = wb_match(IQ_PRN_W'(disp_src_prn[s]));
      disp_entry.src[s].prn       = IQ_PRN_W'(disp_src_prn[s]);
      disp_entry.src[s].rdy       = disp_src_rdy[s] || dp_m[64];
      disp_entry.src[s].val       = disp_src_rdy[s] ? disp_src_val[s] : dp_m[63:0];
      disp_entry.dst_prn[s]       = IQ_PRN_W'(disp_dst_prn[s]);
    end
  end

  always_comb begin
    entries_d  = shifted;
    count_left = count_q - CNT_W'(issue);
    count_d    = count_left + CNT_W'(dispatch);
    if (dispatch) entries_d[count_left[IDX_W-1:0]] = disp_entry;
    if (flush) begin
      for (int e = 0; e < DEPTH; e++) entries_d[e] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
    end else begin
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= entries_d[e];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid_q    <= 1'b0;
      inst_q          <= '0;
      inst_id_q       <= '0;
      pc_q            <= '0;
      out_prn_valid_q <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        op_q[s]      <= '0;
        out_prn_q[s] <= '0;
      end
    end else begin
      inst_valid_q <= issue;
      if (issue) begin
        inst_q          <= woken[sel_idx].inst;
        inst_id_q       <= ID_W'(woken[sel_idx].inst_id);
        pc_q            <= woken[sel_idx].pc;
        out_prn_valid_q <= woken[sel_idx].dst_prn_valid;
        for (int s = 0; s < NUM_SRC; s++) begin
          op_q[s]      <= woken[sel_idx].src[s].val;
          out_prn_q[s] <= PRN_W'(woken[sel_idx].dst_prn[s]);
        end
      end
    end
  end

  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_id       = inst_id_q;
  assign pc            = pc_q;
  assign op            = op_q;
  assign out_prn       = out_prn_q;
  assign out_prn_valid = out_prn_valid_q;

endmodule

// File: doc/fu_issue_queue.md
# fu_issue_queue

Issue-side counterpart of the functional-unit interface. Buffers dispatched instructions for one functional unit, such as the data-processing-immediate unit. Captures operand values from the writeback broadcast as they become available. Issues the oldest fully-ready instruction to the FU, driving `inst_valid`, `inst`, `inst_id`, `pc`, `op[0..2]` and `out_prn[0..2]`/`out_prn_valid`, gated by `fu_ready`.

## Interface
Parameters:
- `DEPTH`, 8: entry count, power of two, ≥2
- `PRN_W`, 6: physical register number width
- `ID_W`, 6: instruction id width

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: discard all entries and any pending issue
- `disp_valid` in 1: dispatch request
- `disp_ready` out 1: queue can accept this cycle
- `disp_inst` in 32: instruction word
- `disp_inst_id` in ID_W: ROB id
- `disp_pc` in 64: instruction PC
- `disp_src_prn[3]` in PRN_W each: source PRNs
- `disp_src_rdy[3]` in 1 each: source already available (unused sources dispatch as ready)
- `disp_src_val[3]` in 64 each: value when ready
- `disp_dst_prn[3]` in PRN_W each: destination PRNs
- `disp_dst_prn_valid[3]` in 1 each: destination used
- `wb_valid` in 1: writeback broadcast valid
- `wb_prn[3]` in PRN_W each: broadcast PRNs
- `wb_data[3]` in 64 each: broadcast data
- `wb_data_valid[3]` in 1 each: lane carries a result
- `fu_ready` in 1: FU accepts an instruction next edge
- `inst_valid` out 1: issue strobe
- `inst` out 32, `inst_id` out ID_W, `pc` out 64: issued instruction
- `op[3]` out 64 each: operand values
- `out_prn[3]` out PRN_W each, `out_prn_valid` out 3: issued destinations

## Operation
- Entry storage is a collapsing queue. Slot 0 is the oldest. `count` is 0..DEPTH.
- `disp_ready = (count < DEPTH) && !flush`. A same-cycle issue does not free a slot for dispatch.
- Dispatch writes the new entry at slot `count` (after collapse if an issue occurs the same cycle).
- Wakeup:
  - Each stored source with `rdy=0` compares `src_prn` against every lane `k` with `wb_valid && wb_data_valid[k]`.
  - On a match, it sets `rdy` and latches `wb_data[k]`.
  - The lowest lane wins multiple matches.
- Dispatch bypass: a dispatching source with `disp_src_rdy=0` that matches a live wb lane the same cycle is stored as ready with that lane's data.
- Select:
  - Candidate set is entries whose 3 sources are all `rdy`.
  - The lowest slot index wins.
  - Selection happens only when `fu_ready=1`.
- Issue: the winner's fields load into the output register, `inst_valid` goes to 1 for exactly one cycle, and the entry is removed with younger entries shifting down one slot.
- No winner or `fu_ready=0` drives `inst_valid` to 0 next cycle. Other output fields hold.
- `flush`: next edge sets `count=0` and `inst_valid=0`. Same-cycle dispatch and wakeup are dropped.

## Timing
- Reset values:
  - `count=0`, all entries invalid
  - `inst_valid=0`, `inst=0`, `inst_id=0`, `pc=0`
  - `op[*]=0`, `out_prn[*]=0`, `out_prn_valid=0`
  - `disp_ready=1` once `rst` deasserts
- Dispatch with all sources ready in cycle N: eligible for select in N+1, `inst_valid=1` in N+2.
- Wakeup in cycle N (stored entry): select in N+1, `inst_valid` in N+2 (without bypass macro).
- Back-to-back issue: one instruction per cycle while `fu_ready=1` and candidates exist.
- Full queue with issue in cycle N: `disp_ready=1` in N+1.
- `rst` mid-operation clears everything asynchronously, including an in-flight `inst_valid`.

## Configuration
- `FU_IQ_WAKEUP_BYPASS_EN` defined:
  - A stored source matched by wb in cycle N counts as ready for select in N, with its operand muxed from `wb_data`.
  - Wakeup-to-`inst_valid` latency drops to 1 cycle.
- Undefined: select uses only stored `rdy` bits, giving 2-cycle wakeup-to-`inst_valid`.
- Dispatch-bypass behaviour is identical in both builds.

## Structure
- `fu_iq_pkg` holds:
  - `iq_src_t` struct {prn, rdy, val}
  - `iq_entry_t` struct {valid, inst, inst_id, pc, src[3], dst_prn[3], dst_prn_valid[3]}
  - `NUM_SRC=3`, `NUM_WB=3` constants
- One sub-module, `fu_iq_select`: DEPTH-wide lowest-index-first picker returning a one-hot grant and binary index.

## Test plan
- Reset, then dispatch MOVZ `inst=32'hD2800020`, id 5, all sources ready, `fu_ready=1` → `inst_valid=1` exactly two cycles later with `inst_id=5`, then 0.
- Dispatch id 1 with `src0` prn 12 not ready, then id 2 all ready → id 2 issues first. A wb broadcast of prn 12 with data `64'hAB` → id 1 issues with `op[0]=64'hAB` two cycles later (one with `FU_IQ_WAKEUP_BYPASS_EN`).
- Dispatch with `disp_src_rdy=0` for prn 9 while wb broadcasts prn 9 data `64'h55` in the same cycle → entry stored ready and issued with `op[0]=64'h55`.
- Fill 8 entries with `fu_ready=0` → `disp_ready=0` and `inst_valid=0`. Raise `fu_ready` → ids issue in dispatch order, one per cycle, and `disp_ready=1` the cycle after the first issue.
- Queue holds 4 entries, assert `flush` with `disp_valid=1` → next cycle `count=0`, `inst_valid=0`, and nothing issues afterward.
- Assert `rst` between clock edges while `inst_valid=1` → `inst_valid=0` immediately, and the queue is empty after release.
